// File: rtl/herm_extract.sv
// herm_extract: Rx Hermitian extractor; keeps bins 1..ACTIVE_SUBCARR of every FFT symbol, buffers one burst, then streams it out
// Ports: clk; rst (sync, active high); din/din_valid/din_ready FFT bin stream in ([15:8] imag, [7:0] real, signed);
//        dout/dout_valid/dout_ready extracted points out; burst_done high after the last point until rx_done;
//        rx_done soft clear back to FILL (buffer contents kept).
// Optional: define HERM_MIRROR_CHECK_EN to add sticky herm_err, flagging a mirror bin that is not the conjugate
//        of its stored data bin, or a nonzero DC bin.
module herm_extract #(
    parameter int ACTIVE_SUBCARR = 28,
    parameter int SYMBOL_NUM     = 8,
    parameter int FFT_POINT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        burst_done,
`ifdef HERM_MIRROR_CHECK_EN
    output logic        herm_err,
`endif
    input  logic        rx_done
);
    localparam int DEPTH = ACTIVE_SUBCARR * SYMBOL_NUM;
    localparam int BW = FFT_POINT > 1 ? $clog2(FFT_POINT) : 1;
    localparam int SW = SYMBOL_NUM > 1 ? $clog2(SYMBOL_NUM) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   buff [DEPTH];
    logic [BW-1:0] bin_cnt;
    logic [SW-1:0] sym_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          clr, accept, last_bin, last_sym, active, start, xfer, last_xfer;

    always_comb begin
        clr       = rst || rx_done;
        accept    = state == FILL && din_valid;
        last_bin  = bin_cnt == BW'(FFT_POINT - 1);
        last_sym  = sym_cnt == SW'(SYMBOL_NUM - 1);
        active    = bin_cnt != '0 && bin_cnt <= BW'(ACTIVE_SUBCARR);
        // first DRAIN cycle primes dout with entry 0 before any handshake
        start     = state == DRAIN && !dout_valid && rd_ptr == '0;
        xfer      = state == DRAIN && dout_valid && dout_ready;
        // rd_ptr runs one ahead of the entry held in dout
        last_xfer = xfer && rd_ptr == PW'(DEPTH);
        state_nxt = (accept && last_bin && last_sym) ? DRAIN : last_xfer ? DONE : state;
    end

    assign din_ready = state == FILL;

    always_ff @(posedge clk) begin
        if (clr) state <= FILL;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept && active) buff[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bin_cnt    <= '0;
            sym_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            if (accept) begin
                bin_cnt <= last_bin ? '0 : bin_cnt + BW'(1);
                if (last_bin) sym_cnt <= last_sym ? '0 : sym_cnt + SW'(1);
                if (active) wr_ptr <= wr_ptr + PW'(1);
            end
            if (start) begin
                dout       <= buff[0];
                rd_ptr     <= PW'(1);
                dout_valid <= 1'b1;
            end else if (last_xfer) begin
                dout_valid <= 1'b0;
                burst_done <= 1'b1;
            end else if (xfer) begin
                dout   <= buff[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef HERM_MIRROR_CHECK_EN
    logic [PW-1:0] m_idx;
    logic [15:0]   m_ref;
    logic          m_bad;

    // mirror bin b pairs with data bin k = FFT_POINT-b of the symbol being filled
    always_comb begin
        m_idx = PW'(int'(sym_cnt) * ACTIVE_SUBCARR + FFT_POINT - int'(bin_cnt) - 1);
        m_ref = buff[m_idx];
        m_bad = bin_cnt >= BW'(FFT_POINT - ACTIVE_SUBCARR)
              ? (din[7:0] != m_ref[7:0] || din[15:8] != 8'(~m_ref[15:8] + 8'd1))
              : (bin_cnt == '0 && din != '0);
    end

    always_ff @(posedge clk) begin
        if (clr) herm_err <= 1'b0;
        else     herm_err <= herm_err || (accept && m_bad);
    end
`endif
endmodule
